audio_volume_ctrl: RTL and testbench
====================================

Name: audio_volume_ctrl

Overview:
- Sample-processing stage between the I2S receiver and the two PWM DAC channels.
- Takes 24-bit signed L/R samples with a valid strobe and applies a 16-step volume with saturation and mute.
- Converts each channel to 12-bit offset-binary DAC codes.
- Volume is stepped by two debounced active-low push-buttons; the same clock domain as the I2S block (50 MHz) is used throughout.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a raw key must be stable before it is accepted (20 ms at 50 MHz).
- VOL_DEFAULT, 8, volume step loaded at reset; 8 = unity gain.
- VOL_MAX, 15, upper clamp of the volume step; must be ≤ 15.

Ports:
- clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- in_valid  input  1  one-cycle strobe; in_L/in_R are valid
- in_L  input  24  left sample, two's complement
- in_R  input  24  right sample, two's complement
- key_up_n  input  1  raw volume-up button, active-low, asynchronous
- key_down_n  input  1  raw volume-down button, active-low, asynchronous
- mute_en  input  1  level; 1 forces gain 0
- out_valid  output  1  one-cycle strobe; dac_L/dac_R updated this cycle
- dac_L  output  12  left DAC code, offset-binary, 2048 = zero
- dac_R  output  12  right DAC code, offset-binary
- vol_level  output  4  current volume step
- clip  output  1  pulses with out_valid if either channel saturated

Behaviour:
- Reset: vol_level=VOL_DEFAULT, dac_L=dac_R=2048, out_valid=0, clip=0, pipeline valids cleared, debounce counters and synchronizers cleared to the released state (1).
- Reset mid-operation: in-flight samples are dropped and no out_valid is produced for them. Reset has priority over all other events.
- Key path:
  - Each key passes through a 2-FF synchronizer, then a counter that restarts on any change of the synced level.
  - The debounced level updates after DEBOUNCE_CYCLES consecutive equal cycles.
  - A press event is a debounced 1->0 transition. Exactly one step per press; no auto-repeat.
  - Release needs no action beyond re-arming.
  - A bounce shorter than DEBOUNCE_CYCLES produces no event.
- Volume register:
  - up event: +1, clamped at VOL_MAX.
  - down event: -1, clamped at 0.
  - up and down events in the same cycle: no change.
  - Updates take effect for samples whose in_valid arrives on or after the cycle following the update.
- Gain: g = mute_en ? 0 : vol_level, sampled in stage 1.
- Pipeline, 2 cycles: in_valid at cycle n gives out_valid at cycle n+2. Back-to-back in_valid on every cycle is supported.
  - Stage 1 (registered): p = in_X × g. Signed 24 × unsigned 5 (zero-extended) gives a 29-bit signed product.
  - Stage 2 (registered):
    - q = p >>> 3 (arithmetic, floor).
    - Saturate q to 24-bit signed [-8388608, 8388607]; sat_X=1 if clamped.
    - s = q_sat >>> 12 (12-bit signed, floor).
    - dac_X = s with MSB inverted (s + 2048), range 0..4095.
    - clip = sat_L | sat_R, asserted only together with out_valid.
- dac_L/dac_R hold their last value between out_valid pulses; out_valid and clip are 0 otherwise.
- g=0 always yields dac=2048 and clip=0.

Test Plan:
- Reset for 2 cycles, no input -> dac_L=dac_R=2048, vol_level=8, out_valid=0, clip=0.
- vol 8, in_valid with in_L=0x100000, in_R=0xF00000 at cycle n -> out_valid at n+2 only; dac_L=2304, dac_R=1792, clip=0. With vol 4: dac_L=2176, dac_R=1920.
- vol 15, in_L=0x7FFFFF, in_R=0x800000 -> dac_L=4095, dac_R=0, clip=1. Then in_L=0x010000, in_R=0 -> dac_L=2078, dac_R=2048, clip=0.
- DEBOUNCE_CYCLES=4: key_up_n low 2 cycles then high -> vol stays 8. Held low 10 cycles -> vol 9 exactly once. 8 clean presses -> vol 15 (clamped). 20 down presses -> vol 0. Simultaneous up/down press -> unchanged.
- mute_en=1, in_L=in_R=0x400000 -> dac 2048/2048, clip=0, vol_level unchanged. mute_en=0 next sample -> dac_L=3072.
- in_valid at cycle n, Reset at n+1 -> no out_valid at n+2, dac=2048. Then in_valid on 4 consecutive cycles -> 4 consecutive out_valid pulses in order.

Source files
------------

// File: rtl/audio_volume_ctrl_if.sv
// Sample stream bundle between the I2S receiver, the volume stage and the PWM DACs.
// master drives samples in and receives DAC codes; slave is the volume stage itself.
interface audio_volume_ctrl_if;
    logic               in_valid;
    logic signed [23:0] in_L;
    logic signed [23:0] in_R;
    logic               out_valid;
    logic        [11:0] dac_L;
    logic        [11:0] dac_R;
    logic               clip;

    modport master (
        output in_valid, in_L, in_R,
        input  out_valid, dac_L, dac_R, clip
    );

    modport slave (
        input  in_valid, in_L, in_R,
        output out_valid, dac_L, dac_R, clip
    );
endinterface

// File: rtl/audio_volume_ctrl.sv
// Stereo volume stage: debounced up/down keys set a 16-step gain, samples are scaled,
// saturated and converted to 12-bit offset-binary DAC codes over a 2-cycle pipeline.
module audio_volume_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int VOL_DEFAULT     = 8,
    parameter int VOL_MAX         = 15
) (
    input  logic                clk,
    input  logic                Reset,
    audio_volume_ctrl_if.slave  sif,
    input  logic                key_up_n,
    input  logic                key_down_n,
    input  logic                mute_en,
    output logic [3:0]          vol_level
);
    localparam int DATA_W = 24;
    localparam int COEF_W = 5;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int Q_W    = PROD_W - 3;
    localparam int DAC_W  = 12;
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

    // Signed sample times zero-extended unsigned gain; the result always fits PROD_W.
    function automatic logic signed [PROD_W-1:0] mul_gain(
        input logic signed [DATA_W-1:0] x,
        input logic        [COEF_W-1:0] g
    );
        return PROD_W'(x) * $signed(PROD_W'(g));
    endfunction

    // Returns {sat, dac}: divide by 8 (floor), clamp to 24-bit, keep top 12 bits, flip MSB.
    function automatic logic [DAC_W:0] sat_to_dac(input logic signed [PROD_W-1:0] p);
        logic signed [Q_W-1:0]    q;
        logic signed [DATA_W-1:0] q_sat;
        logic signed [DAC_W-1:0]  s;
        logic                     sat;
        q   = Q_W'(p >>> 3);
        sat = (q[Q_W-1:DATA_W-1] != '0) && (q[Q_W-1:DATA_W-1] != '1);
        if (!sat)
            q_sat = DATA_W'(q);
        else if (q[Q_W-1])
            q_sat = {1'b1, {(DATA_W-1){1'b0}}};
        else
            q_sat = {1'b0, {(DATA_W-1){1'b1}}};
        s = DAC_W'(q_sat >>> (DATA_W - DAC_W));
        return {sat, ~s[DAC_W-1], s[DAC_W-2:0]};
    endfunction

    // Key path: bit 0 = up, bit 1 = down. Released level is 1.
    logic [1:0]       key_raw;
    logic [1:0]       key_meta;
    logic [1:0]       key_sync;
    logic [1:0]       key_db;
    logic [1:0]       press_evt;
    logic [CNT_W-1:0] key_cnt [2];

    assign key_raw = {key_down_n, key_up_n};

    // The counter only runs while the synced level differs from the debounced one,
    // so any return to the old level restarts the qualification window.
    always_ff @(posedge clk) begin
        if (Reset) begin
            key_meta  <= '1;
            key_sync  <= '1;
            key_db    <= '1;
            press_evt <= '0;
            for (int i = 0; i < 2; i++)
                key_cnt[i] <= '0;
        end else begin
            key_meta  <= key_raw;
            key_sync  <= key_meta;
            press_evt <= '0;
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == key_db[i]) begin
                    key_cnt[i] <= '0;
                end else if (key_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_cnt[i]   <= '0;
                    key_db[i]    <= key_sync[i];
                    press_evt[i] <= ~key_sync[i];
                end else begin
                    key_cnt[i] <= key_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset)
            vol_level <= 4'(VOL_DEFAULT);
        else if (press_evt == 2'b01 && vol_level < 4'(VOL_MAX))
            vol_level <= vol_level + 4'd1;
        else if (press_evt == 2'b10 && vol_level != 4'd0)
            vol_level <= vol_level - 4'd1;
    end

    // Stage 1: gain multiply
    logic [COEF_W-1:0]        gain;
    logic                     vld_p1;
    logic signed [PROD_W-1:0] prod_l_p1;
    logic signed [PROD_W-1:0] prod_r_p1;

    assign gain = mute_en ? '0 : {1'b0, vol_level};

    always_ff @(posedge clk) begin
        if (Reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= sif.in_valid;
    end

    always_ff @(posedge clk) begin
        if (sif.in_valid) begin
            prod_l_p1 <= mul_gain(sif.in_L, gain);
            prod_r_p1 <= mul_gain(sif.in_R, gain);
        end
    end

    // Stage 2: scale, saturate, convert to offset binary
    logic [DAC_W:0] res_l;
    logic [DAC_W:0] res_r;

    assign res_l = sat_to_dac(prod_l_p1);
    assign res_r = sat_to_dac(prod_r_p1);

    always_ff @(posedge clk) begin
        if (Reset) begin
            sif.out_valid <= 1'b0;
            sif.clip      <= 1'b0;
            sif.dac_L     <= 12'd2048;
            sif.dac_R     <= 12'd2048;
        end else begin
            sif.out_valid <= vld_p1;
            sif.clip      <= vld_p1 & (res_l[DAC_W] | res_r[DAC_W]);
            if (vld_p1) begin
                sif.dac_L <= res_l[DAC_W-1:0];
                sif.dac_R <= res_r[DAC_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_audio_volume_ctrl.sv
// Bench for audio_volume_ctrl: directed cases plus randomized traffic against an
// arithmetic reference model with an expected-output queue keyed by due cycle.
module tb_audio_volume_ctrl;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       Reset;
    logic       key_up_n;
    logic       key_down_n;
    logic       mute_en;
    logic [3:0] vol_level;

    always #5 clk = ~clk;

    audio_volume_ctrl_if sif();

    audio_volume_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .VOL_DEFAULT(8),
        .VOL_MAX(15)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .sif(sif.slave),
        .key_up_n(key_up_n),
        .key_down_n(key_down_n),
        .mute_en(mute_en),
        .vol_level(vol_level)
    );

    typedef struct {
        int          due;
        logic [11:0] l;
        logic [11:0] r;
        logic        clip;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    int   model_vol = 8;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: out = floor(clamp(floor(x*g/8)) / 4096) + 2048
    function automatic void ref_model(input logic signed [23:0] x, input int g,
                                      output logic [11:0] d, output logic sat);
        longint p, q, s;
        p   = longint'(x) * longint'(g);
        q   = p >>> 3;
        sat = 1'b0;
        if (q > 64'sd8388607) begin
            q = 64'sd8388607; sat = 1'b1;
        end else if (q < -64'sd8388608) begin
            q = -64'sd8388608; sat = 1'b1;
        end
        s = q >>> 12;
        d = 12'(s + 2048);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [23:0] l, input logic signed [23:0] r, input logic m);
        exp_t e;
        logic sl, sr;
        int   g;
        g = m ? 0 : model_vol;
        ref_model(l, g, e.l, sl);
        ref_model(r, g, e.r, sr);
        e.clip = sl | sr;
        e.due  = cyc + 2;
        exp_q.push_back(e);
        sif.in_valid = 1'b1;
        sif.in_L     = l;
        sif.in_R     = r;
        mute_en      = m;
        step();
        sif.in_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc)
            void'(exp_q.pop_back());
        repeat (n) step();
        Reset     = 1'b0;
        model_vol = 8;
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        if (up) key_up_n = 1'b0;
        if (dn) key_down_n = 1'b0;
        repeat (hold) step();
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (12) step();
        if (hold >= 2 * DEB && (up != dn)) begin
            if (up && model_vol < 15) model_vol++;
            if (dn && model_vol > 0) model_vol--;
        end
        chk("vol_level", 32'(vol_level), 32'(model_vol));
    endtask

    // Output monitor: every out_valid must match the queue head due this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic exp_now;
        exp_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (sif.out_valid || exp_now) begin
            chk("out_valid", 32'(sif.out_valid), 32'(exp_now));
            if (exp_now) begin
                e = exp_q.pop_front();
                chk("dac_L", 32'(sif.dac_L), 32'(e.l));
                chk("dac_R", 32'(sif.dac_R), 32'(e.r));
                chk("clip", 32'(sif.clip), 32'(e.clip));
            end
        end else if (sif.clip) begin
            chk("clip_idle", 32'(sif.clip), 32'd0);
        end
    end

    initial begin
        Reset        = 1'b1;
        key_up_n     = 1'b1;
        key_down_n   = 1'b1;
        mute_en      = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_L     = '0;
        sif.in_R     = '0;
        repeat (2) step();
        chk("rst_dac_L", 32'(sif.dac_L), 32'd2048);
        chk("rst_dac_R", 32'(sif.dac_R), 32'd2048);
        chk("rst_vol", 32'(vol_level), 32'd8);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_clip", 32'(sif.clip), 32'd0);
        Reset = 1'b0;
        step();

        // Unity gain, latency of exactly two cycles
        send(24'sh100000, 24'shF00000, 1'b0);
        chk("lat_n1", 32'(sif.out_valid), 32'd0);
        step();
        chk("lat_n2", 32'(sif.out_valid), 32'd1);
        chk("u_dac_L", 32'(sif.dac_L), 32'd2304);
        chk("u_dac_R", 32'(sif.dac_R), 32'd1792);
        step();
        chk("lat_n3", 32'(sif.out_valid), 32'd0);

        // Debounce: short bounce ignored, long press steps once, clamps at both ends
        press(1, 0, 2);
        press(1, 0, 10);
        chk("vol_9", 32'(vol_level), 32'd9);
        for (int i = 0; i < 8; i++) press(1, 0, 10);
        chk("vol_max", 32'(vol_level), 32'd15);
        for (int i = 0; i < 20; i++) press(0, 1, 10);
        chk("vol_min", 32'(vol_level), 32'd0);
        press(1, 0, 10);
        press(1, 1, 10);
        chk("vol_simul", 32'(vol_level), 32'd1);
        for (int i = 0; i < 3; i++) press(1, 0, 10);

        send(24'sh100000, 24'shF00000, 1'b0);
        step();
        chk("v4_dac_L", 32'(sif.dac_L), 32'd2176);
        chk("v4_dac_R", 32'(sif.dac_R), 32'd1920);
        step();

        // Saturation at full gain, then back-to-back unsaturated sample
        for (int i = 0; i < 11; i++) press(1, 0, 10);
        send(24'sh7FFFFF, 24'sh800000, 1'b0);
        send(24'sh010000, 24'sh000000, 1'b0);
        chk("sat_dac_L", 32'(sif.dac_L), 32'd4095);
        chk("sat_dac_R", 32'(sif.dac_R), 32'd0);
        chk("sat_clip", 32'(sif.clip), 32'd1);
        step();
        chk("ns_dac_L", 32'(sif.dac_L), 32'd2078);
        chk("ns_dac_R", 32'(sif.dac_R), 32'd2048);
        chk("ns_clip", 32'(sif.clip), 32'd0);
        step();

        // Mute forces zero gain without touching the volume step
        for (int i = 0; i < 7; i++) press(0, 1, 10);
        send(24'sh400000, 24'sh400000, 1'b1);
        step();
        chk("mute_dac_L", 32'(sif.dac_L), 32'd2048);
        chk("mute_dac_R", 32'(sif.dac_R), 32'd2048);
        chk("mute_clip", 32'(sif.clip), 32'd0);
        chk("mute_vol", 32'(vol_level), 32'd8);
        send(24'sh400000, 24'sh400000, 1'b0);
        step();
        chk("unmute_dac_L", 32'(sif.dac_L), 32'd3072);
        step();

        // Reset one cycle after a sample drops it
        send(24'sh200000, 24'sh200000, 1'b0);
        do_reset(1);
        chk("rst_drop_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_drop_dac", 32'(sif.dac_L), 32'd2048);
        for (int i = 0; i < 4; i++)
            send(24'(i * 24'sh080000 + 24'sh001000), 24'(-(i * 24'sh040000)), 1'b0);
        repeat (4) step();
        chk("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Randomized traffic with occasional key presses and resets
        for (int it = 0; it < 400; it++) begin
            int act;
            act = int'($urandom_range(0, 99));
            if (act < 6) begin
                press(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 2 : 10);
            end else if (act < 8) begin
                do_reset(int'($urandom_range(1, 3)));
            end else if (act < 20) begin
                step();
            end else begin
                logic signed [23:0] l, r;
                int                 k;
                k = int'($urandom_range(0, 3));
                l = (k == 0) ? 24'sh7FFFFF : (k == 1) ? 24'sh800000 : 24'($urandom);
                r = 24'($urandom);
                send(l, r, ($urandom_range(0, 4) == 0));
            end
        end
        repeat (5) step();
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
